// File: rtl/result_reader.sv
// Reads the seven Fibonacci results and the running sum, checks them against the expected constants.
// Latency: done in cycle 8*(READ_LAT+1)+1 after start; no backpressure, start is dropped unless idle.
module result_reader #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       rd,
    output logic [7:0] addr,
    input  logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic [6:0] F_ok,
    output logic       sum_ok,
    output logic       pass,
    output logic [7:0] err_addr
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] WAIT_LAST = 2'(READ_LAT - 1);

    function automatic logic [7:0] seq_addr(input logic [2:0] i);
        if (i == 3'd7) return 8'hF3;
        return 8'hF8 + {5'd0, i};
    endfunction

    function automatic logic [7:0] exp_val(input logic [2:0] i);
        case (i)
            3'd0:    return 8'h01;
            3'd1:    return 8'h01;
            3'd2:    return 8'h02;
            3'd3:    return 8'h03;
            3'd4:    return 8'h05;
            3'd5:    return 8'h08;
            3'd6:    return 8'h0D;
            default: return 8'h21;
        endcase
    endfunction

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic [1:0] wcnt;
    logic       accept;
    logic       sample;
    logic       last_idx;
    logic       match;
    logic [6:0] f_ok_nxt;
    logic       sum_ok_nxt;
    logic [7:0] err_nxt;

    assign last_idx = (idx == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        addr      = 8'h00;
        busy      = (state != IDLE);
        done      = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                rd        = 1'b1;
                addr      = seq_addr(idx);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wcnt == WAIT_LAST) begin
                    sample    = 1'b1;
                    state_nxt = last_idx ? DONE : ISSUE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the first failing location in sequence order is recorded.
    always_comb begin
        match      = (rdata == exp_val(idx));
        f_ok_nxt   = F_ok;
        sum_ok_nxt = sum_ok;
        err_nxt    = err_addr;
        if (match) begin
            if (last_idx) sum_ok_nxt = 1'b1;
            else          f_ok_nxt   = F_ok | (7'd1 << idx);
        end else if (err_addr == 8'h00) begin
            err_nxt = seq_addr(idx);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx      <= 3'd0;
            wcnt     <= 2'd0;
            F_ok     <= 7'd0;
            sum_ok   <= 1'b0;
            pass     <= 1'b0;
            err_addr <= 8'h00;
        end else begin
            if (accept) begin
                idx      <= 3'd0;
                F_ok     <= 7'd0;
                sum_ok   <= 1'b0;
                pass     <= 1'b0;
                err_addr <= 8'h00;
            end
            if (state == ISSUE) wcnt <= 2'd0;
            else if (state == WAIT) wcnt <= wcnt + 2'd1;
            if (sample) begin
                F_ok     <= f_ok_nxt;
                sum_ok   <= sum_ok_nxt;
                err_addr <= err_nxt;
                if (last_idx) pass <= (&f_ok_nxt) & sum_ok_nxt;
                else          idx  <= idx + 3'd1;
            end
        end
    end

endmodule

// File: doc/result_reader.md
# result_reader

Bus-side readback unit for the Fibonacci lab program, used after the CPU has finished its write stream. On a start pulse it reads the seven Fibonacci result locations (0xF8–0xFE) and the running-sum location (0xF3) from data memory, one read at a time. It compares each value against the fixed expected constants and reports per-location match flags, an overall pass, and the first failing address. It sits on the memory read port beside the CPU, with memory access muxed to it while `busy` is high.

## Interface
- `READ_LAT`, default 1: memory read latency in cycles, legal range 1..3.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a readback; ignored while `busy`.
- `rd`  out  1  memory read strobe, one cycle per access.
- `addr`  out  8  read address; 0x00 whenever `rd` is low.
- `rdata`  in  8  memory read data; valid `READ_LAT` cycles after the `rd` cycle.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when all 8 comparisons are complete.
- `F_ok`  out  7  bit i = 1 if address 0xF8+i matched its expected value.
- `sum_ok`  out  1  address 0xF3 matched 0x21.
- `pass`  out  1  `&F_ok & sum_ok`; updated with `done` and held until the next accepted start.
- `err_addr`  out  8  lowest-sequence-index failing address; 0x00 if none.

## Operation
- Read sequence, index 0..7: 0xF8, 0xF9, 0xFA, 0xFB, 0xFC, 0xFD, 0xFE, 0xF3.
- Expected values in the same order: 0x01, 0x01, 0x02, 0x03, 0x05, 0x08, 0x0D, 0x21.
- State machine states:
  - IDLE: `start` high → ISSUE. Index is set to 0. `F_ok`, `sum_ok`, `pass` are cleared to 0 and `err_addr` to 0x00.
  - ISSUE: drives `rd=1` and `addr`=seq[index] for exactly one cycle, then → WAIT.
  - WAIT: counts `READ_LAT` cycles. In the last one, samples `rdata` and compares it with expected[index].
    - On a match, sets the flag bit.
    - On a mismatch, loads `err_addr` only if it is still 0x00.
    - Then → ISSUE with index+1, or → DONE if index==7.
  - DONE: `done`=1 and `pass` is registered, for one cycle, then → IDLE.
- The index counter is 3 bits and never wraps mid-sequence. The exit to DONE is taken at index 7.
- `start` is ignored in every state except IDLE; no queuing.
- Comparison is an exact 8-bit equality. Upper bits that differ count as a mismatch, e.g. 0x81 at 0xF8 fails.
- Flags and `err_addr` from a completed run are held in IDLE until the next accepted start.

## Timing
- Reset values:
  - `rd` 0, `addr` 0x00, `busy` 0, `done` 0.
  - `F_ok` 0, `sum_ok` 0, `pass` 0, `err_addr` 0x00.
  - State IDLE.
- `start` is sampled at edge E0. The first `rd` is high in the cycle after E0 (cycle 1).
- Each access takes 1 + `READ_LAT` cycles, and the next `rd` follows immediately. `rd` is never high on consecutive cycles.
- `rdata` for an `rd` in cycle t is sampled at the end of cycle t+`READ_LAT`.
- `done` occurs in cycle 8·(`READ_LAT`+1)+1 after the start edge: cycle 17 for `READ_LAT`=1, cycle 33 for `READ_LAT`=3.
- `busy` is high from cycle 1 through the `done` cycle inclusive.
- `start` asserted in the `done` cycle is ignored. A start in the first IDLE cycle after that is accepted.
- Reset asserted mid-run returns everything to reset values at the next edge; `rd` is 0 in the following cycle. Any in-flight read is discarded.

## Test plan
- Normal run, memory preloaded with the correct values, `READ_LAT`=1, start at cycle 0:
  - `rd` pulses in cycles 1, 3, …, 15 with `addr` F8…FE, F3.
  - `done` in cycle 17, with `F_ok`=0x7F, `sum_ok`=1, `pass`=1, `err_addr`=0x00.
- Single mismatch, 0xFB holds 0x04: `F_ok`=0x77, `sum_ok`=1, `pass`=0, `err_addr`=0xFB.
- Multiple mismatches, 0xFA=0x00 and 0xF3=0x20: `F_ok`=0x7B, `sum_ok`=0, `err_addr`=0xFA (first failure wins).
- Start while busy: pulse `start` again at cycle 6.
  - The sequence is unchanged and `done` still occurs in cycle 17.
  - No extra `rd` occurs after `done`.
- Reset mid-run: assert `reset` at cycle 8.
  - Next cycle: `rd`=0, `busy`=0, all flags 0.
  - A new start then completes normally with `pass`=1.
- `READ_LAT`=3 with correct memory: `rd` every 4 cycles (1, 5, …, 29), `done` in cycle 33, `pass`=1.
